spi_cmd_scheduler: RTL and testbench

SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

---
 rtl/spi_cmd_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_spi_cmd_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_scheduler.sv
// SPI command scheduler: decodes received SPI words, stages register writes in a FIFO,
// drains them to the actuator bank on commit, and times the actuator fire pulse.
module spi_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_n,
  input  logic              latch_data_n,
  input  logic              trigger_in_n,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic [31:0]       tx_word,
  output logic              tx_load,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              fire,
  output logic              busy,
  output logic              err_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  typedef enum logic [0:0] {ST_IDLE, ST_DRAIN} state_t;

  state_t state, state_next;

  logic [1:0] en_sync_n;
  logic [2:0] latch_sync_n;
  logic [2:0] trig_sync_n;
  logic       enabled, latch_fall, trig_fall;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, push_ok, drop, pop;
  logic [ENT_W-1:0] head;

  logic [1:0]        op;
  logic [ADDR_W-1:0] word_addr;
  logic              accept, commit_req;
  logic              trig_pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Read response: A5 marker, address in byte 2, read data in the low half.
  function automatic logic [31:0] read_resp(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = 32'h0;
    r[31:24] = 8'hA5;
    r[16 +: ADDR_W] = a;
    r[DATA_W-1:0] = d;
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_sync_n    <= '1;
      latch_sync_n <= '1;
      trig_sync_n  <= '1;
    end else begin
      en_sync_n    <= {en_sync_n[0], enable_n};
      latch_sync_n <= {latch_sync_n[1:0], latch_data_n};
      trig_sync_n  <= {trig_sync_n[1:0], trigger_in_n};
    end
  end

  assign enabled    = ~en_sync_n[1];
  assign latch_fall = latch_sync_n[2] & ~latch_sync_n[1];
  assign trig_fall  = trig_sync_n[2] & ~trig_sync_n[1];

  assign op         = word_data[31:30];
  assign word_addr  = word_data[24 +: ADDR_W];
  assign accept     = word_valid & enabled;
  assign commit_req = latch_fall | (accept & (op == OP_COMMIT));

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop     = reg_wr_en;
  assign push    = accept & (op == OP_WRITE);
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    reg_wr_en  = 1'b0;
    if (!enabled) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit_req) state_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!empty) begin
            reg_wr_en = 1'b1;
          end else if (!push) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy        = (state == ST_DRAIN);
  assign reg_addr    = busy ? head[ENT_W-1 -: ADDR_W] : word_addr;
  assign reg_wr_data = head[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!enabled) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {word_addr, word_data[DATA_W-1:0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_word      <= 32'h0;
      tx_load      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      tx_load <= accept;
      if (accept) tx_word <= (op == OP_READ) ? read_resp(word_addr, reg_rd_data) : word_data;
      if (drop) begin
        err_overflow <= 1'b1;
      end else if (accept && (op == OP_NOP) && word_data[0]) begin
        err_overflow <= 1'b0;
      end
    end
  end

  // Triggers seen while draining wait until the FSM is back in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fire         <= 1'b0;
      trig_pending <= 1'b0;
    end else if (!enabled) begin
      fire         <= 1'b0;
      trig_pending <= 1'b0;
    end else if (busy) begin
      fire <= 1'b0;
      if (trig_fall) trig_pending <= 1'b1;
    end else begin
      fire         <= trig_fall | trig_pending;
      trig_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Scoreboard bench for spi_cmd_scheduler: expected tx words and register writes are
// queued as stimulus is driven and compared when the DUT emits tx_load / reg_wr_en.
module tb_spi_cmd_scheduler;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset_n, enable_n, latch_data_n, trigger_in_n, word_valid;
  logic [31:0]       word_data;
  logic [31:0]       tx_word;
  logic              tx_load, reg_wr_en, fire, busy, err_overflow;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data, reg_rd_data;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, busy_cycles = 0, fire_count = 0, wr_count = 0, tx_count = 0;
  logic [31:0] exp_tx[$];
  logic [31:0] exp_wr[$];
  int          wr_time[$];

  always #5 clock = ~clock;

  spi_cmd_scheduler #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable_n(enable_n), .latch_data_n(latch_data_n),
    .trigger_in_n(trigger_in_n), .word_valid(word_valid), .word_data(word_data),
    .tx_word(tx_word), .tx_load(tx_load), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .fire(fire), .busy(busy),
    .err_overflow(err_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] a,
                                     input logic [15:0] d);
    logic [31:0] w;
    w = 32'h0;
    w[31:30] = op;
    w[28:24] = a;
    w[15:0]  = d;
    return w;
  endfunction

  function automatic logic [31:0] wr_exp(input logic [4:0] a, input logic [15:0] d);
    return {11'b0, a, d};
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (busy) busy_cycles++;
    if (fire) fire_count++;
    if (tx_load) begin
      tx_count++;
      if (exp_tx.size() > 0) check("tx_word", tx_word, exp_tx.pop_front());
      else check("tx_unexpected", 32'd1, 32'd0);
    end
    if (reg_wr_en) begin
      wr_count++;
      wr_time.push_back(cyc);
      if (exp_wr.size() > 0) check("reg_write", {11'b0, reg_addr, reg_wr_data}, exp_wr.pop_front());
      else check("write_unexpected", 32'd1, 32'd0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w);
    @(posedge clock);
    #1;
    word_data  = w;
    word_valid = 1'b1;
    @(posedge clock);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic send_echo(input logic [31:0] w);
    exp_tx.push_back(w);
    drive_word(w);
  endtask

  task automatic stage(input logic [4:0] a, input logic [15:0] d);
    exp_wr.push_back(wr_exp(a, d));
    send_echo(mk(2'b01, a, d));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, f0, t0;
    reset_n = 1'b0; enable_n = 1'b1; latch_data_n = 1'b1; trigger_in_n = 1'b1;
    word_valid = 1'b0; word_data = 32'h0; reg_rd_data = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tx_word", tx_word, 32'h0);
    check("rst_tx_load", tx_load, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_fire", fire, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overflow, 0);
    reset_n = 1'b1;
    enable_n = 1'b0;
    wait_cycles(5);

    // Echo: NOP words come back unchanged.
    send_echo(32'h3EEF_FACE);
    send_echo(32'h0000_0000);
    wait_cycles(2);
    check("echo_tx_count", tx_count, 2);

    // 0xBEEF_FACE carries op=10, so it decodes as a READ of address 0x1E.
    reg_rd_data = 16'h0F0F;
    exp_tx.push_back(32'hA51E_0F0F);
    drive_word(32'hBEEF_FACE);

    // Stage two writes, commit via latch pad.
    busy_cycles = 0; w0 = wr_count;
    stage(5'd3, 16'h1234);
    stage(5'd7, 16'hABCD);
    latch_data_n = 1'b0;
    wait_cycles(4);
    latch_data_n = 1'b1;
    wait_cycles(4);
    check("latch_busy_cycles", busy_cycles, 3);
    check("latch_write_count", wr_count - w0, 2);
    check("latch_write_gap", wr_time[wr_time.size()-1] - wr_time[wr_time.size()-2], 1);

    // Overflow: fifth write dropped.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) stage(5'(i + 1), 16'h1000 + 16'(i));
      else send_echo(mk(2'b01, 5'd5, 16'h1004));
    end
    @(negedge clock);
    check("ovf_err_set", err_overflow, 1);
    w0 = wr_count;
    send_echo(mk(2'b11, 5'd0, 16'h0));
    wait_cycles(8);
    check("ovf_write_count", wr_count - w0, 4);
    check("ovf_err_sticky", err_overflow, 1);
    send_echo(32'h0000_0001);
    @(negedge clock);
    check("ovf_err_clear", err_overflow, 0);

    // Read response, with read address presented during word_valid.
    reg_rd_data = 16'h5A5A;
    exp_tx.push_back(32'hA509_5A5A);
    @(posedge clock);
    #1;
    word_data = mk(2'b10, 5'd9, 16'h0);
    word_valid = 1'b1;
    @(negedge clock);
    check("read_addr", reg_addr, 9);
    @(posedge clock);
    #1;
    word_valid = 1'b0;
    wait_cycles(2);

    // Trigger in IDLE: fire three cycles after the pad edge.
    f0 = fire_count;
    @(posedge clock);
    #1;
    trigger_in_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("fire_idle", fire, (i == 3));
    end
    trigger_in_n = 1'b1;
    wait_cycles(3);
    check("fire_idle_count", fire_count - f0, 1);

    // Trigger during DRAIN: deferred until after busy falls.
    stage(5'd1, 16'h0111);
    stage(5'd2, 16'h0222);
    stage(5'd4, 16'h0444);
    trigger_in_n = 1'b0;
    send_echo(mk(2'b11, 5'd0, 16'h0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!busy) break;
      check("fire_quiet_drain", fire, 0);
    end
    check("drain_ended", busy, 0);
    check("fire_not_yet", fire, 0);
    @(negedge clock);
    check("fire_after_drain", fire, 1);
    @(negedge clock);
    check("fire_one_cycle", fire, 0);
    trigger_in_n = 1'b1;
    wait_cycles(2);

    // Disabled: words ignored, no fire, staged writes flushed.
    send_echo(mk(2'b01, 5'd6, 16'h0666));
    send_echo(mk(2'b01, 5'd8, 16'h0888));
    enable_n = 1'b1;
    wait_cycles(4);
    f0 = fire_count; t0 = tx_count;
    trigger_in_n = 1'b0;
    drive_word(mk(2'b00, 5'd0, 16'h0));
    wait_cycles(6);
    trigger_in_n = 1'b1;
    check("dis_no_fire", fire_count - f0, 0);
    check("dis_no_tx", tx_count - t0, 0);
    enable_n = 1'b0;
    wait_cycles(4);
    busy_cycles = 0; w0 = wr_count;
    send_echo(mk(2'b11, 5'd0, 16'h0));
    wait_cycles(4);
    check("empty_commit_busy", busy_cycles, 1);
    check("flushed_no_writes", wr_count - w0, 0);

    // Reset mid-DRAIN discards remaining entries.
    exp_wr.push_back(wr_exp(5'd10, 16'h0A0A));
    send_echo(mk(2'b01, 5'd10, 16'h0A0A));
    send_echo(mk(2'b01, 5'd11, 16'h0B0B));
    send_echo(mk(2'b01, 5'd12, 16'h0C0C));
    w0 = wr_count;
    send_echo(mk(2'b11, 5'd0, 16'h0));
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("rstd_wr_en", reg_wr_en, 0);
    check("rstd_busy", busy, 0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(5);
    check("rstd_busy_after", busy, 0);
    check("rstd_write_count", wr_count - w0, 1);
    busy_cycles = 0;
    send_echo(mk(2'b11, 5'd0, 16'h0));
    wait_cycles(4);
    check("rstd_commit_busy", busy_cycles, 1);
    check("rstd_commit_writes", wr_count - w0, 1);

    wait_cycles(2);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
